// File: rtl/mem_pkg.sv
// Shared defaults and types for the memory request responder.
// Pure declarations; no logic, no latency, no flow control.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH   = 4;
  localparam int MEM_DATA_WIDTH   = 32;
  localparam int MEM_READ_LATENCY = 1;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [MEM_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line of {valid, data} stages, synchronously cleared.
// Latency READ_LATENCY cycles; no backpressure, accepts one entry every cycle.
module mem_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("mem_rd_pipe: READ_LATENCY must be in 1..4");
  end

  logic [READ_LATENCY-1:0] stage_vld;
  logic [DATA_WIDTH-1:0]   stage_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] prev_vld;
  logic [DATA_WIDTH-1:0]   prev_dat  [READ_LATENCY];

  always_comb begin
    prev_vld    = '0;
    prev_dat[0] = in_dat;
    prev_vld[0] = in_vld;
    for (int i = 1; i < READ_LATENCY; i++) begin
      prev_vld[i] = stage_vld[i-1];
      prev_dat[i] = stage_dat[i-1];
    end
  end

  // The final stage only loads on a valid entry so the output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) stage_dat[i] <= '0;
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_vld[i] <= prev_vld[i];
        if (i != READ_LATENCY - 1 || prev_vld[i]) stage_dat[i] <= prev_dat[i];
      end
    end
  end

  assign out_vld = stage_vld[READ_LATENCY-1];
  assign out_dat = stage_dat[READ_LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port synchronous RAM answering en/wen/Addr/Data_in requests.
// Writes commit at the edge; reads return after READ_LATENCY cycles; no backpressure.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int READ_LATENCY = MEM_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  mem_op_e               op;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_dat;

  assign op     = mem_op_e'(wen);
  assign rd_vld = en && (op == MEM_RD);
  assign rd_dat = mem[Addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en && op == MEM_WR) begin
      mem[Addr] <= Data_in;
    end
  end

  // Reset also clears the pipe input stage, so requests seen during reset vanish.
  mem_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_vld (rd_vld),
    .in_dat (rd_dat),
    .out_vld(Valid),
    .out_dat(Data_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(en) && !(en && $isunknown(wen)))
      else $error("mem_responder: unknown en/wen outside reset");
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at READ_LATENCY=3, checking Valid/Data_out every cycle.
module tb_mem_responder;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          wen;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] Data_out;
  logic          Valid;

  int checks   = 0;
  int failures = 0;

  logic          exp_v [LAT];
  logic [DW-1:0] exp_d [LAT];
  logic [DW-1:0] exp_hold;

  mem_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wen     (wen),
    .Addr    (Addr),
    .Data_in (Data_in),
    .Data_out(Data_out),
    .Valid   (Valid)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; rd_exp is the hand-computed word a read must return.
  task automatic step(input logic r, input logic e, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] rd_exp, input string tag);
    rst = r; en = e; wen = w; Addr = a; Data_in = d;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < LAT; i++) begin
        exp_v[i] = 1'b0;
        exp_d[i] = '0;
      end
      exp_hold = '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        exp_v[i] = exp_v[i-1];
        exp_d[i] = exp_d[i-1];
      end
      exp_v[0] = e && !w;
      exp_d[0] = rd_exp;
    end
    checks++;
    assert (Valid === exp_v[LAT-1])
    else begin
      failures++;
      $error("FAIL %s valid got=%0b exp=%0b", tag, Valid, exp_v[LAT-1]);
    end
    if (exp_v[LAT-1]) exp_hold = exp_d[LAT-1];
    checks++;
    assert (Data_out === exp_hold)
    else begin
      failures++;
      $error("FAIL %s data got=%08h exp=%08h", tag, Data_out, exp_hold);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    step(1'b0, 1'b1, 1'b1, a, d, '0, tag);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] x, input string tag);
    step(1'b0, 1'b1, 1'b0, a, '0, x, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 1'b0; Addr = '0; Data_in = '0;
    for (int i = 0; i < LAT; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
    end
    exp_hold = '0;

    // 1: reset clears memory; a write during reset is dropped
    step(1'b1, 1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, '0, "reset0");
    step(1'b1, 1'b1, 1'b0, 4'd0, '0, '0, "reset1");
    for (int i = 0; i < 16; i++) rd(AW'(i), 32'h0, "rd_after_reset");
    idle(LAT, "drain1");

    // 2: write then read same address on the next cycle
    wr(4'd5, 32'hDEAD_BEEF, "wr5");
    rd(4'd5, 32'hDEAD_BEEF, "rd5");
    idle(LAT + 1, "drain2");

    // 3: fill and stream back-to-back
    for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i * 32'h11), "fill");
    for (int i = 0; i < 16; i++) rd(AW'(i), DW'(i * 32'h11), "stream");
    idle(LAT, "drain3");

    // 4: read issued before an overlapping write returns the old word
    wr(4'd3, 32'h0000_000A, "wrA");
    rd(4'd3, 32'h0000_000A, "rd_old");
    wr(4'd3, 32'h0000_000B, "wrB");
    idle(LAT, "drain4");
    rd(4'd3, 32'h0000_000B, "rd_new");
    idle(LAT, "drain4b");

    // 5: reset with reads in flight discards them and clears memory
    rd(4'd1, 32'h0000_0011, "inflight1");
    rd(4'd2, 32'h0000_0022, "inflight2");
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, "midreset");
    idle(LAT + 1, "post_reset_idle");
    rd(4'd1, 32'h0, "rd1_after_reset");
    idle(LAT, "drain5");

    // 6: Data_out holds across idle cycles, memory unchanged
    wr(4'd7, 32'h0000_1234, "wr7");
    rd(4'd7, 32'h0000_1234, "rd7");
    idle(LAT + 10, "hold");
    rd(4'd7, 32'h0000_1234, "rd7_again");
    rd(4'd0, 32'h0, "rd0_untouched");
    idle(LAT, "drain6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
